uart_rx_ctrl: RTL and testbench

// Serial receive controller that feeds a flex_counter_reg-style bit timer (drives clear/save/enable) and consumes its

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rx_ctrl_sync2.sv | 27 ++
 rtl/uart_rx_ctrl.sv | 159 +++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive controller.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        WAIT   = 3'd5
    } state_t;

    localparam int DATA_BITS = 8;

endpackage

// File: rtl/uart_rx_ctrl_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic n_rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops; reset to the line's idle level so no edge is seen out of reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART 8N1 (optional even parity) receive controller driving an external bit timer.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_BITS     = 4,
    parameter int PARITY_EN    = 0
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                serial_in,
    input  logic [CNT_BITS-1:0] timer_count,
    input  logic                timer_rollover,
    output logic                timer_clear,
    output logic                timer_enable,
    output logic                timer_save,
    output logic [7:0]          rx_data,
    output logic                rx_valid,
    input  logic                rx_ready,
    output logic                rx_busy,
    output logic                framing_err,
    output logic                parity_err,
    output logic                overrun_err
);

    localparam logic [CNT_BITS-1:0] HALF    = CNT_BITS'(CLKS_PER_BIT / 2);
    localparam logic [2:0]          LAST_BIT = 3'(DATA_BITS - 1);

    state_t     state_q;
    logic [2:0] bit_idx_q;
    logic [7:0] shreg_q;
    logic       par_bad_q;
    logic [7:0] rx_data_q;
    logic       rx_valid_q;
    logic       framing_err_q;
    logic       parity_err_q;
    logic       overrun_err_q;
    logic       prev_q;
    logic       sync_w;
    logic       fall_w;
    logic       sample_pt_w;
    logic       accept_w;

    sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .n_rst (n_rst),
        .d     (serial_in),
        .q     (sync_w)
    );

    // Edge-detect flop behind the synchroniser.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= sync_w;
        end
    end

    assign fall_w      = prev_q & ~sync_w;
    assign sample_pt_w = (timer_count == HALF) & timer_enable;

    // A start sample that reads high is a false start and is not accepted.
    always_comb begin
        accept_w = 1'b0;
        case (state_q)
            START:             accept_w = ~sync_w;
            DATA, PARITY, STOP: accept_w = 1'b1;
            default:           accept_w = 1'b0;
        endcase
    end

    assign timer_enable = (state_q != IDLE);
    assign timer_clear  = (state_q == IDLE);
    assign timer_save   = sample_pt_w & accept_w;
    assign rx_busy      = (state_q != IDLE);

    // Frame FSM with byte assembly, publish/handshake and one-cycle error pulses.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= IDLE;
            bit_idx_q     <= 3'd0;
            shreg_q       <= 8'd0;
            par_bad_q     <= 1'b0;
            rx_data_q     <= 8'd0;
            rx_valid_q    <= 1'b0;
            framing_err_q <= 1'b0;
            parity_err_q  <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            framing_err_q <= 1'b0;
            parity_err_q  <= 1'b0;
            overrun_err_q <= 1'b0;
            if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (fall_w) begin
                        state_q <= START;
                    end
                end
                START: begin
                    if (sample_pt_w) begin
                        if (sync_w) begin
                            state_q <= IDLE;
                        end else begin
                            bit_idx_q <= 3'd0;
                            par_bad_q <= 1'b0;
                            state_q   <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (sample_pt_w) begin
                        shreg_q[bit_idx_q] <= sync_w;
                        if (bit_idx_q == LAST_BIT) begin
                            state_q <= (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (sample_pt_w) begin
                        par_bad_q <= (^shreg_q) ^ sync_w;
                        state_q   <= STOP;
                    end
                end
                STOP: begin
                    if (sample_pt_w) begin
                        parity_err_q <= par_bad_q;
                        if (!sync_w) begin
                            framing_err_q <= 1'b1;
                        end else begin
                            rx_data_q     <= shreg_q;
                            rx_valid_q    <= 1'b1;
                            overrun_err_q <= rx_valid_q & ~rx_ready;
                        end
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (timer_rollover) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign framing_err = framing_err_q;
    assign parity_err  = parity_err_q;
    assign overrun_err = overrun_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: one DUT without parity, one with parity, each with a bit-timer model.
module tb_uart_rx_ctrl;

    localparam int CPB  = 16;
    localparam int CNTW = 5;
    localparam int GAP  = 24;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic serial_a = 1'b1;
    logic serial_b = 1'b1;
    logic ready_a = 1'b1;
    logic ready_b = 1'b1;

    logic [CNTW-1:0] cnt_a, cnt_b;
    logic flag_a, flag_b;
    logic clr_a, en_a, save_a, valid_a, busy_a, fe_a, pe_a, ov_a;
    logic clr_b, en_b, save_b, valid_b, busy_b, fe_b, pe_b, ov_b;
    logic [7:0] data_a, data_b;

    int total = 0;
    int bad = 0;

    int fe_a_cnt = 0, pe_a_cnt = 0, ov_a_cnt = 0, vrise_a = 0, vcyc_a = 0, save_a_cnt = 0;
    int fe_b_cnt = 0, pe_b_cnt = 0, ov_b_cnt = 0, vrise_b = 0, save_b_cnt = 0;
    logic vprev_a = 1'b0, vprev_b = 1'b0;

    always #5 clk = ~clk;

    uart_rx_ctrl #(.CLKS_PER_BIT(CPB), .CNT_BITS(CNTW), .PARITY_EN(0)) dut_a (
        .clk(clk), .n_rst(n_rst), .serial_in(serial_a),
        .timer_count(cnt_a), .timer_rollover(flag_a),
        .timer_clear(clr_a), .timer_enable(en_a), .timer_save(save_a),
        .rx_data(data_a), .rx_valid(valid_a), .rx_ready(ready_a), .rx_busy(busy_a),
        .framing_err(fe_a), .parity_err(pe_a), .overrun_err(ov_a)
    );

    uart_rx_ctrl #(.CLKS_PER_BIT(CPB), .CNT_BITS(CNTW), .PARITY_EN(1)) dut_b (
        .clk(clk), .n_rst(n_rst), .serial_in(serial_b),
        .timer_count(cnt_b), .timer_rollover(flag_b),
        .timer_clear(clr_b), .timer_enable(en_b), .timer_save(save_b),
        .rx_data(data_b), .rx_valid(valid_b), .rx_ready(ready_b), .rx_busy(busy_b),
        .framing_err(fe_b), .parity_err(pe_b), .overrun_err(ov_b)
    );

    // Bit-timer models: clear wins, count 1..CPB after the first pass, flag one cycle after count==CPB.
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_a <= '0; flag_a <= 1'b0;
        end else if (clr_a) begin
            cnt_a <= '0; flag_a <= 1'b0;
        end else if (en_a) begin
            cnt_a  <= (cnt_a == CNTW'(CPB)) ? CNTW'(1) : cnt_a + CNTW'(1);
            flag_a <= (cnt_a == CNTW'(CPB));
        end
    end

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_b <= '0; flag_b <= 1'b0;
        end else if (clr_b) begin
            cnt_b <= '0; flag_b <= 1'b0;
        end else if (en_b) begin
            cnt_b  <= (cnt_b == CNTW'(CPB)) ? CNTW'(1) : cnt_b + CNTW'(1);
            flag_b <= (cnt_b == CNTW'(CPB));
        end
    end

    // Event counters for pulses and valid activity, sampled on the falling edge.
    always @(negedge clk) begin
        fe_a_cnt   <= fe_a_cnt + int'(fe_a);
        pe_a_cnt   <= pe_a_cnt + int'(pe_a);
        ov_a_cnt   <= ov_a_cnt + int'(ov_a);
        save_a_cnt <= save_a_cnt + int'(save_a);
        vcyc_a     <= vcyc_a + int'(valid_a);
        vrise_a    <= vrise_a + int'(valid_a & ~vprev_a);
        vprev_a    <= valid_a;
        fe_b_cnt   <= fe_b_cnt + int'(fe_b);
        pe_b_cnt   <= pe_b_cnt + int'(pe_b);
        ov_b_cnt   <= ov_b_cnt + int'(ov_b);
        save_b_cnt <= save_b_cnt + int'(save_b);
        vrise_b    <= vrise_b + int'(valid_b & ~vprev_b);
        vprev_b    <= valid_b;
    end

    task automatic drive_bit(input bit sel, input logic b, input int cycles);
        if (sel) serial_b = b; else serial_a = b;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d, input bit use_par,
                              input logic par, input logic stop, output logic busy_mid);
        drive_bit(sel, 1'b0, CPB);
        busy_mid = sel ? busy_b : busy_a;
        for (int i = 0; i < 8; i++) drive_bit(sel, d[i], CPB);
        if (use_par) drive_bit(sel, par, CPB);
        drive_bit(sel, stop, CPB);
        drive_bit(sel, 1'b1, GAP);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({valid_a, busy_a, fe_a, pe_a, ov_a, en_a, save_a} !== 7'b0 || data_a !== 8'h00) begin
            bad++;
            $display("FAIL reset_a: valid=%b busy=%b fe=%b pe=%b ov=%b en=%b save=%b data=%h, want all 0",
                     valid_a, busy_a, fe_a, pe_a, ov_a, en_a, save_a, data_a);
        end
        total++;
        if ({valid_b, busy_b, fe_b, pe_b, ov_b, en_b, save_b} !== 7'b0 || data_b !== 8'h00) begin
            bad++;
            $display("FAIL reset_b: valid=%b busy=%b data=%h, want 0", valid_b, busy_b, data_b);
        end
        n_rst = 1'b1;
        repeat (4) @(negedge clk);
        $display("reset released");
    endtask

    task automatic test_basic();
        int fe0 = fe_a_cnt, pe0 = pe_a_cnt, ov0 = ov_a_cnt, vr0 = vrise_a, vc0 = vcyc_a, sv0 = save_a_cnt;
        logic bm;
        ready_a = 1'b1;
        send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, bm);
        $display("frame A5: data=%h busy_mid=%b", data_a, bm);
        total++;
        if (bm !== 1'b1) begin bad++; $display("FAIL basic_busy_mid: got %b want 1", bm); end
        total++;
        if (data_a !== 8'hA5) begin bad++; $display("FAIL basic_data: got %h want a5", data_a); end
        total++;
        if (vrise_a - vr0 != 1 || vcyc_a - vc0 != 1) begin
            bad++; $display("FAIL basic_valid: rises=%0d cycles=%0d want 1/1", vrise_a - vr0, vcyc_a - vc0);
        end
        total++;
        if (fe_a_cnt != fe0 || pe_a_cnt != pe0 || ov_a_cnt != ov0) begin
            bad++; $display("FAIL basic_errs: fe=%0d pe=%0d ov=%0d want 0", fe_a_cnt - fe0, pe_a_cnt - pe0, ov_a_cnt - ov0);
        end
        total++;
        if (save_a_cnt - sv0 != 10) begin bad++; $display("FAIL basic_saves: got %0d want 10", save_a_cnt - sv0); end
        total++;
        if (busy_a !== 1'b0 || valid_a !== 1'b0) begin
            bad++; $display("FAIL basic_idle: busy=%b valid=%b want 0/0", busy_a, valid_a);
        end
    endtask

    task automatic test_glitch();
        int fe0 = fe_a_cnt, vr0 = vrise_a, sv0 = save_a_cnt;
        logic bm;
        drive_bit(1'b0, 1'b0, 4);
        drive_bit(1'b0, 1'b1, 4);
        bm = busy_a;
        drive_bit(1'b0, 1'b1, 2 * CPB);
        $display("glitch: busy_mid=%b busy_end=%b", bm, busy_a);
        total++;
        if (bm !== 1'b1) begin bad++; $display("FAIL glitch_start: busy=%b want 1", bm); end
        total++;
        if (busy_a !== 1'b0) begin bad++; $display("FAIL glitch_idle: busy=%b want 0", busy_a); end
        total++;
        if (vrise_a != vr0 || fe_a_cnt != fe0 || save_a_cnt != sv0 || pe_a_cnt != 0 || ov_a_cnt != 0) begin
            bad++; $display("FAIL glitch_quiet: valid=%0d fe=%0d save=%0d want 0", vrise_a - vr0, fe_a_cnt - fe0, save_a_cnt - sv0);
        end
    endtask

    task automatic test_framing();
        int fe0 = fe_a_cnt, vr0 = vrise_a;
        logic bm;
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, bm);
        $display("frame 3C stop=0: fe=%0d valid=%0d", fe_a_cnt - fe0, vrise_a - vr0);
        total++;
        if (fe_a_cnt - fe0 != 1) begin bad++; $display("FAIL framing_pulse: got %0d want 1", fe_a_cnt - fe0); end
        total++;
        if (vrise_a != vr0 || data_a !== 8'hA5) begin
            bad++; $display("FAIL framing_drop: valid=%0d data=%h want 0/a5", vrise_a - vr0, data_a);
        end
        fe0 = fe_a_cnt; vr0 = vrise_a;
        send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1, bm);
        $display("frame 55: data=%h", data_a);
        total++;
        if (data_a !== 8'h55 || vrise_a - vr0 != 1 || fe_a_cnt != fe0) begin
            bad++; $display("FAIL framing_next: data=%h valid=%0d fe=%0d want 55/1/0", data_a, vrise_a - vr0, fe_a_cnt - fe0);
        end
    endtask

    task automatic test_overrun();
        int ov0 = ov_a_cnt;
        logic bm;
        ready_a = 1'b0;
        send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1, bm);
        $display("frame 11 held: data=%h valid=%b", data_a, valid_a);
        total++;
        if (data_a !== 8'h11 || valid_a !== 1'b1 || ov_a_cnt != ov0) begin
            bad++; $display("FAIL overrun_first: data=%h valid=%b ov=%0d want 11/1/0", data_a, valid_a, ov_a_cnt - ov0);
        end
        send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1, bm);
        $display("frame 22 over: data=%h ov=%0d", data_a, ov_a_cnt - ov0);
        total++;
        if (ov_a_cnt - ov0 != 1) begin bad++; $display("FAIL overrun_pulse: got %0d want 1", ov_a_cnt - ov0); end
        total++;
        if (data_a !== 8'h22 || valid_a !== 1'b1) begin
            bad++; $display("FAIL overrun_data: data=%h valid=%b want 22/1", data_a, valid_a);
        end
        ready_a = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (valid_a !== 1'b0) begin bad++; $display("FAIL overrun_drain: valid=%b want 0", valid_a); end
    endtask

    task automatic test_parity();
        int pe0 = pe_b_cnt, vr0 = vrise_b, fe0 = fe_b_cnt, sv0 = save_b_cnt;
        logic bm;
        send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1, bm);
        $display("parity frame 07 p=0: data=%h pe=%0d", data_b, pe_b_cnt - pe0);
        total++;
        if (pe_b_cnt - pe0 != 1) begin bad++; $display("FAIL parity_pulse: got %0d want 1", pe_b_cnt - pe0); end
        total++;
        if (data_b !== 8'h07 || vrise_b - vr0 != 1 || fe_b_cnt != fe0) begin
            bad++; $display("FAIL parity_publish: data=%h valid=%0d fe=%0d want 07/1/0", data_b, vrise_b - vr0, fe_b_cnt - fe0);
        end
        total++;
        if (save_b_cnt - sv0 != 11) begin bad++; $display("FAIL parity_saves: got %0d want 11", save_b_cnt - sv0); end
        pe0 = pe_b_cnt; vr0 = vrise_b;
        send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1, bm);
        $display("parity frame 07 p=1: data=%h pe=%0d", data_b, pe_b_cnt - pe0);
        total++;
        if (pe_b_cnt != pe0 || vrise_b - vr0 != 1 || ov_b_cnt != 0) begin
            bad++; $display("FAIL parity_good: pe=%0d valid=%0d ov=%0d want 0/1/0", pe_b_cnt - pe0, vrise_b - vr0, ov_b_cnt);
        end
    endtask

    task automatic test_midreset();
        int fe0 = fe_a_cnt, vr0 = vrise_a;
        logic bm;
        drive_bit(1'b0, 1'b0, CPB);
        for (int i = 0; i < 4; i++) drive_bit(1'b0, 1'b1, CPB);
        drive_bit(1'b0, 1'b1, CPB / 2);
        bm = busy_a;
        n_rst = 1'b0;
        #1;
        $display("mid-frame reset: busy_before=%b busy=%b data=%h", bm, busy_a, data_a);
        total++;
        if (bm !== 1'b1) begin bad++; $display("FAIL midreset_busy_before: got %b want 1", bm); end
        total++;
        if (busy_a !== 1'b0 || valid_a !== 1'b0 || data_a !== 8'h00 || en_a !== 1'b0) begin
            bad++; $display("FAIL midreset_outputs: busy=%b valid=%b data=%h en=%b want 0", busy_a, valid_a, data_a, en_a);
        end
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        drive_bit(1'b0, 1'b1, 2 * CPB);
        send_frame(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, bm);
        $display("frame FF after reset: data=%h", data_a);
        total++;
        if (data_a !== 8'hFF || vrise_a - vr0 != 1 || fe_a_cnt != fe0 || ov_a_cnt != 1) begin
            bad++; $display("FAIL midreset_next: data=%h valid=%0d fe=%0d ov_total=%0d want ff/1/0/1",
                            data_a, vrise_a - vr0, fe_a_cnt - fe0, ov_a_cnt);
        end
        total++;
        if (pe_a_cnt != 0) begin bad++; $display("FAIL noparity_pe: got %0d want 0", pe_a_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_framing();
        test_overrun();
        test_parity();
        test_midreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
